// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the sequenced 8x8 multiplier built from a 4x4 core.
package approx_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int         N_STEPS   = 4;
    localparam logic [1:0] LAST_STEP = 2'(N_STEPS - 1);

    // Partial-product weight for each step: aL*bL, aL*bH, aH*bL, aH*bH.
    localparam logic [3:0] SHIFT_TAB [N_STEPS] = '{4'd0, 4'd4, 4'd4, 4'd8};

    // Bit k set means step k feeds the high nibble of that operand to the core.
    localparam logic [N_STEPS-1:0] A_HI_SEL = 4'b1100;
    localparam logic [N_STEPS-1:0] B_HI_SEL = 4'b1010;

    function automatic logic [3:0] nib(input logic [7:0] v, input logic hi);
        return hi ? v[7:4] : v[3:0];
    endfunction

endpackage

// File: rtl/mul8_seq_acc.sv
// Shift-add accumulator: adds (addend << shift) into a 16-bit sum, carry-out sticks in ovf.
module mul8_seq_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  addend,
    input  logic [3:0]  shift,
    output logic [15:0] acc,
    output logic        ovf
);

    logic [16:0] sum;

    // Full 17-bit sum so the carry out of bit 15 is visible.
    always_comb begin
        sum = {1'b0, acc} + (17'(addend) << shift);
    end

    // Clear wins over accumulate; the two are never requested together by the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            acc <= sum[15:0];
            ovf <= ovf | sum[16];
        end
    end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequencer that forms an 8x8 product from four passes through an external 4x4 core.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// in_ready does not depend on in_valid; out_valid, once high, stays high with r/ovf
// frozen until the edge where out_ready is also high.
module mul8_seq_ctrl
    import approx_mul_pkg::*;
#(
    parameter bit CORE_REG = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [3:0]  core_a,
    output logic [3:0]  core_b,
    input  logic [7:0]  core_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] r,
    output logic        ovf,
    output logic        busy,
    output state_t      dbg_state
);

    state_t     state;
    logic [1:0] k;
    logic [1:0] k_nxt;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] core_r_q;
    logic [7:0] addend;
    logic       accept;
    logic       acc_en;

    assign in_ready  = !rst && (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign k_nxt     = k + 2'd1;
    assign dbg_state = state;

    // Accumulate in the cycle the core product is valid: STEP when combinational, WAIT when captured.
    assign acc_en = CORE_REG ? (state == WAIT) : (state == STEP);
    assign addend = CORE_REG ? core_r_q : core_r;

    // Main sequencer: accept, walk the four nibble steps, then hold the result in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            a_q       <= '0;
            b_q       <= '0;
            core_a    <= '0;
            core_b    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            // Also covers DONE with out_ready: handoff and new operands in the same edge.
            state     <= STEP;
            k         <= '0;
            a_q       <= a;
            b_q       <= b;
            core_a    <= nib(a, A_HI_SEL[0]);
            core_b    <= nib(b, B_HI_SEL[0]);
            out_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                STEP, WAIT: begin
                    if (state == STEP && CORE_REG) begin
                        state <= WAIT;
                    end else if (k == LAST_STEP) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        core_a    <= '0;
                        core_b    <= '0;
                    end else begin
                        state  <= STEP;
                        k      <= k_nxt;
                        core_a <= nib(a_q, A_HI_SEL[k_nxt]);
                        core_b <= nib(b_q, B_HI_SEL[k_nxt]);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture the core product at the end of STEP for use in the following WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_r_q <= '0;
        end else if (state == STEP) begin
            core_r_q <= core_r;
        end
    end

    mul8_seq_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (acc_en),
        .addend (addend),
        .shift  (SHIFT_TAB[k]),
        .acc    (r),
        .ovf    (ovf)
    );

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Bench for mul8_seq_ctrl: unit 0 uses CORE_REG=0, unit 1 uses CORE_REG=1.
module tb_mul8_seq_ctrl;
  import approx_mul_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [7:0]  a          [2];
  logic [7:0]  b          [2];
  logic [3:0]  core_a     [2];
  logic [3:0]  core_b     [2];
  logic [7:0]  core_r     [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [15:0] r          [2];
  logic        ovf        [2];
  logic        busy       [2];
  state_t      dbg_state  [2];
  logic        core_force [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mul8_seq_ctrl #(.CORE_REG(g == 1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a[g]),
      .b         (b[g]),
      .core_a    (core_a[g]),
      .core_b    (core_b[g]),
      .core_r    (core_r[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .r         (r[g]),
      .ovf       (ovf[g]),
      .busy      (busy[g]),
      .dbg_state (dbg_state[g])
    );
    // Exact 4x4 core, or a stuck-at-255 core to provoke overflow.
    assign core_r[g] = core_force[g] ? 8'hff : ({4'b0, core_a[g]} * {4'b0, core_b[g]});
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s unit%0d actual=%0d required=%0d time=%0t", name, u, act, exp, $time);
    end
  endfunction

  // Expected {ovf, r} straight from arithmetic on the operands.
  function automatic logic [16:0] model(input logic [7:0] x, input logic [7:0] y, input logic frc);
    int total;
    if (frc) total = 255 * (1 + 16 + 16 + 256);
    else     total = x * y;
    return {(total > 65535), total[15:0]};
  endfunction

  logic [16:0] exp_q [2][$];
  int          m_cnt   [2];
  logic        m_valid [2];
  logic [15:0] m_r     [2];
  logic        m_ovf   [2];
  logic [7:0]  m_a     [2];
  logic [7:0]  m_b     [2];
  int          sa_hi [4] = '{0, 0, 1, 1};
  int          sb_hi [4] = '{0, 1, 0, 1};

  // Every-cycle compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin : compare
    logic        eb;
    logic        eir;
    logic        fire;
    int          k;
    logic [16:0] e;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_cnt[u]   = 0;
        m_valid[u] = 1'b0;
        exp_q[u].delete();
      end
      eb  = (m_cnt[u] > 0);
      eir = !rst && ((!eb && !m_valid[u]) || (m_valid[u] && out_ready[u]));
      chk("in_ready", u, in_ready[u], eir);
      chk("out_valid", u, out_valid[u], m_valid[u]);
      chk("busy", u, busy[u], eb);
      if (eb) begin
        k = (N_STEPS * (u + 1) - m_cnt[u]) / (u + 1);
        chk("core_a", u, core_a[u], (sa_hi[k] != 0) ? m_a[u][7:4] : m_a[u][3:0]);
        chk("core_b", u, core_b[u], (sb_hi[k] != 0) ? m_b[u][7:4] : m_b[u][3:0]);
      end else begin
        chk("core_a_idle", u, core_a[u], 0);
        chk("core_b_idle", u, core_b[u], 0);
      end
      if (m_valid[u]) begin
        chk("r", u, r[u], m_r[u]);
        chk("ovf", u, ovf[u], m_ovf[u]);
      end
      if (!rst) begin
        fire = in_valid[u] && eir;
        if (m_valid[u] && out_ready[u]) m_valid[u] = 1'b0;
        if (m_cnt[u] > 0) begin
          m_cnt[u] = m_cnt[u] - 1;
          if (m_cnt[u] == 0) begin
            e = (exp_q[u].size() > 0) ? exp_q[u].pop_front() : 17'h0;
            m_valid[u] = 1'b1;
            m_r[u]     = e[15:0];
            m_ovf[u]   = e[16];
          end
        end
        if (fire) begin
          m_a[u]   = a[u];
          m_b[u]   = b[u];
          m_cnt[u] = N_STEPS * (u + 1);
          exp_q[u].push_back(model(a[u], b[u], core_force[u]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] rec_q[$];

  task automatic send(input int u, input logic [7:0] av, input logic [7:0] bv);
    int t;
    @(posedge clk); #1;
    in_valid[u] = 1'b1;
    a[u] = av;
    b[u] = bv;
    t = 0;
    @(negedge clk);
    while (!in_ready[u] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("accept_seen", u, in_ready[u], 1);
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    a[u] = 8'($urandom);
    b[u] = 8'($urandom);
  endtask

  // Starts right after the accept edge; lat counts cycles, the first one after that edge being 1.
  task automatic get(input int u, output logic [15:0] rv, output logic ov, output int lat);
    out_ready[u] = 1'b1;
    rec_q.delete();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy[u]) rec_q.push_back({core_a[u], core_b[u]});
    end while (!out_valid[u] && lat < 40);
    chk("result_seen", u, out_valid[u], 1);
    rv = r[u];
    ov = ovf[u];
    @(posedge clk); #1;
  endtask

  task automatic stream(input int u, input int n);
    int t;
    int last;
    @(posedge clk); #1;
    out_ready[u] = 1'b1;
    in_valid[u]  = 1'b1;
    a[u] = 8'($urandom);
    b[u] = 8'($urandom);
    last = 0;
    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge clk);
      while (!in_ready[u] && t < 40) begin
        @(negedge clk);
        t++;
      end
      chk("stream_accept", u, in_ready[u], 1);
      if (i > 0) chk("stream_spacing", u, cyc - last, (u == 1) ? 9 : 5);
      last = cyc;
      @(posedge clk); #1;
      a[u] = 8'($urandom);
      b[u] = 8'($urandom);
    end
    in_valid[u] = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] rv;
  logic        ov;
  int          lat;
  int          t;

  initial begin
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0;
      out_ready[u] = 1'b1;
      a[u] = '0;
      b[u] = '0;
      core_force[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 0, in_ready[0], 1);
    chk("in_ready_after_reset", 1, in_ready[1], 1);

    // Worked example with the exact core.
    send(0, 8'd200, 8'd150);
    get(0, rv, ov, lat);
    chk("r_200x150", 0, rv, 30000);
    chk("ovf_200x150", 0, ov, 0);
    chk("latency", 0, lat, 5);
    chk("nibble_steps", 0, rec_q.size(), 4);
    chk("nibble_k0", 0, rec_q[0], 8'h86);
    chk("nibble_k1", 0, rec_q[1], 8'h89);
    chk("nibble_k2", 0, rec_q[2], 8'hC6);
    chk("nibble_k3", 0, rec_q[3], 8'hC9);

    send(0, 8'd255, 8'd255);
    get(0, rv, ov, lat);
    chk("r_255x255", 0, rv, 65025);
    chk("ovf_255x255", 0, ov, 0);

    send(0, 8'd0, 8'd77);
    get(0, rv, ov, lat);
    chk("r_0x77", 0, rv, 0);

    // Stuck core: 255 on every step overflows only on the last add.
    core_force[0] = 1'b1;
    send(0, 8'($urandom), 8'($urandom));
    get(0, rv, ov, lat);
    chk("r_forced", 0, rv, 8159);
    chk("ovf_forced", 0, ov, 1);
    core_force[0] = 1'b0;
    send(0, 8'd13, 8'd17);
    get(0, rv, ov, lat);
    chk("r_after_forced", 0, rv, 221);
    chk("ovf_after_forced", 0, ov, 0);

    core_force[1] = 1'b1;
    send(1, 8'd3, 8'd4);
    get(1, rv, ov, lat);
    chk("r_forced", 1, rv, 8159);
    chk("ovf_forced", 1, ov, 1);
    chk("latency", 1, lat, 9);
    core_force[1] = 1'b0;
    send(1, 8'd200, 8'd150);
    get(1, rv, ov, lat);
    chk("r_200x150", 1, rv, 30000);
    chk("ovf_200x150", 1, ov, 0);

    // Back-pressure: result held, inputs ignored, then handoff with same-cycle accept.
    out_ready[0] = 1'b0;
    send(0, 8'd123, 8'd45);
    t = 0;
    while (!out_valid[0] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_seen", 0, out_valid[0], 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid[0] = 1'b1;
      a[0] = 8'($urandom);
      b[0] = 8'($urandom);
      @(negedge clk);
      chk("bp_r_hold", 0, r[0], 5535);
      chk("bp_ovf_hold", 0, ovf[0], 0);
      chk("bp_in_ready", 0, in_ready[0], 0);
      chk("bp_out_valid", 0, out_valid[0], 1);
    end
    @(posedge clk); #1;
    a[0] = 8'd7;
    b[0] = 8'd9;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("handoff_in_ready", 0, in_ready[0], 1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("handoff_valid_drop", 0, out_valid[0], 0);
    chk("handoff_busy", 0, busy[0], 1);
    get(0, rv, ov, lat);
    chk("r_after_handoff", 0, rv, 63);

    // Streaming random pairs, out_ready held high.
    stream(0, 100);
    stream(1, 100);

    // Reset during step k2.
    send(0, 8'd99, 8'd201);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_reset_k2", 0, {core_a[0], core_b[0]}, 8'h69);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 0, out_valid[0], 0);
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_core_a", 0, core_a[0], 0);
    chk("rst_core_b", 0, core_b[0], 0);
    chk("rst_in_ready", 0, in_ready[0], 0);
    chk("rst_r", 0, r[0], 0);
    chk("rst_ovf", 0, ovf[0], 0);
    chk("rst_state", 0, 32'(dbg_state[0]), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("no_valid_after_abort", 0, out_valid[0], 0);
    end
    send(0, 8'd17, 8'd240);
    get(0, rv, ov, lat);
    chk("r_after_reset", 0, rv, 4080);
    chk("latency_after_reset", 0, lat, 5);

    repeat (5) @(posedge clk);
    chk("queue_drained", 0, exp_q[0].size(), 0);
    chk("queue_drained", 1, exp_q[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
